wrr_packet_scheduler: RTL and testbench

- Packet-granular weighted round-robin scheduler for one router output port.
- Picks which of CHANNEL_NUMBER input channels owns the output for a whole packet.
- Tracks remaining beats, gates beats on downstream credit availability, and issues a packet-done pulse.
- Pairs with the output mux: grant_id_o drives the mux select, beat_allow_o qualifies TVALID toward the next router.

---
 rtl/wrr_packet_scheduler.sv | 173 +++++++++++++++++
 tb/tb_wrr_packet_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_packet_scheduler.sv
// wrr_packet_scheduler
//   Packet-granular weighted round-robin scheduler for one router output port.
//   A channel owns the output for a whole packet; beats are gated on
//   downstream credits and a registered pkt_done_o pulse follows the last beat.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_i               per-channel packet-head pending (held until granted)
//   len_i               per-channel packet length in beats (0 treated as 1)
//   weight_i            per-channel packets per turn (0 = disabled)
//   beat_fire_i         output beat handshake
//   credit_return_i     downstream freed one slot
//   grant_valid_o       packet in progress
//   grant_o/grant_id_o  one-hot / index of owning channel
//   beat_allow_o        a beat may be issued this cycle
//   credits_o           current downstream credit count
//   pkt_done_o          one-cycle pulse the cycle after the final beat
//
// Optional build macro SCHED_PMU_EN adds performance counters:
//   pmu_clear_i, pmu_pkt_cnt_o (per-channel packets), pmu_stall_cnt_o.
module wrr_packet_scheduler #(
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int LEN_WIDTH            = 8,
  parameter int WEIGHT_WIDTH         = 4,
  parameter int CREDIT_MAX           = 8,
  parameter int CREDIT_INIT          = CREDIT_MAX,
  parameter int CREDIT_WIDTH         = $clog2(CREDIT_MAX+1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [CHANNEL_NUMBER-1:0]             req_i,
  input  logic [CHANNEL_NUMBER*LEN_WIDTH-1:0]   len_i,
  input  logic [CHANNEL_NUMBER*WEIGHT_WIDTH-1:0] weight_i,
  input  logic                                  beat_fire_i,
  input  logic                                  credit_return_i,
  output logic                                  grant_valid_o,
  output logic [CHANNEL_NUMBER-1:0]             grant_o,
  output logic [CHANNEL_NUMBER_WIDTH-1:0]       grant_id_o,
  output logic                                  beat_allow_o,
  output logic [CREDIT_WIDTH-1:0]               credits_o,
  output logic                                  pkt_done_o
`ifdef SCHED_PMU_EN
  ,
  input  logic                                  pmu_clear_i,
  output logic [CHANNEL_NUMBER*32-1:0]          pmu_pkt_cnt_o,
  output logic [31:0]                           pmu_stall_cnt_o
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int CNW = CHANNEL_NUMBER_WIDTH;

  state_t                                   state, state_nxt;
  logic [CHANNEL_NUMBER-1:0][LEN_WIDTH-1:0]    len_arr;
  logic [CHANNEL_NUMBER-1:0][WEIGHT_WIDTH-1:0] wgt_arr;
  logic [CHANNEL_NUMBER-1:0]                eligible;
  logic [CNW-1:0]                           rr_ptr, sel;
  logic                                     found;
  int                                       scan_idx;
  logic [WEIGHT_WIDTH-1:0]                  burst_cnt;
  logic [LEN_WIDTH-1:0]                     beats_left, len_sel;
  logic                                     beat_ok, last_beat, at_max;
  logic [WEIGHT_WIDTH:0]                    burst_inc;

  assign len_arr = len_i;
  assign wgt_arr = weight_i;

  always_comb begin
    for (int i = 0; i < CHANNEL_NUMBER; i++)
      eligible[i] = req_i[i] && (wgt_arr[i] != '0);
  end

  // First eligible channel at or above the pointer, wrapping modulo N.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    scan_idx = 0;
    for (int k = 0; k < CHANNEL_NUMBER; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= CHANNEL_NUMBER) scan_idx = scan_idx - CHANNEL_NUMBER;
      if (!found && eligible[scan_idx]) begin
        found = 1'b1;
        sel   = CNW'(scan_idx);
      end
    end
  end

  assign len_sel       = len_arr[sel];
  assign grant_valid_o = (state == BUSY);
  assign beat_allow_o  = grant_valid_o && (credits_o != '0);
  assign beat_ok       = beat_fire_i && beat_allow_o;
  assign last_beat     = beat_ok && (beats_left == LEN_WIDTH'(1));
  assign at_max        = (credits_o == CREDIT_WIDTH'(CREDIT_MAX));
  assign burst_inc     = {1'b0, burst_cnt} + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)     state_nxt = BUSY;
      BUSY:    if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_o    <= '0;
      grant_id_o <= '0;
      pkt_done_o <= 1'b0;
      rr_ptr     <= '0;
      burst_cnt  <= '0;
      beats_left <= '0;
    end else begin
      pkt_done_o <= 1'b0;
      if (state == IDLE) begin
        if (found) begin
          grant_o    <= CHANNEL_NUMBER'(1) << sel;
          grant_id_o <= sel;
          beats_left <= (len_sel == '0) ? LEN_WIDTH'(1) : len_sel;
          // A burst only continues on the pointer channel.
          if (sel != rr_ptr) burst_cnt <= '0;
        end
      end else if (beat_ok) begin
        beats_left <= beats_left - 1'b1;
        if (last_beat) begin
          pkt_done_o <= 1'b1;
          grant_o    <= '0;
          if (burst_inc < {1'b0, wgt_arr[grant_id_o]}) begin
            burst_cnt <= burst_inc[WEIGHT_WIDTH-1:0];
            rr_ptr    <= grant_id_o;
          end else begin
            burst_cnt <= '0;
            rr_ptr    <= (int'(grant_id_o) == CHANNEL_NUMBER-1) ? '0 : grant_id_o + 1'b1;
          end
        end
      end
    end
  end

  // Return and beat in the same cycle cancel; a return at max is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) credits_o <= CREDIT_WIDTH'(CREDIT_INIT);
    else if (credit_return_i && !beat_ok) begin
      if (!at_max) credits_o <= credits_o + 1'b1;
    end else if (!credit_return_i && beat_ok) credits_o <= credits_o - 1'b1;
  end

`ifdef SCHED_PMU_EN
  logic [CHANNEL_NUMBER-1:0][31:0] pkt_cnt;
  assign pmu_pkt_cnt_o = pkt_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_cnt         <= '0;
      pmu_stall_cnt_o <= '0;
    end else if (pmu_clear_i) begin
      pkt_cnt         <= '0;
      pmu_stall_cnt_o <= '0;
    end else begin
      if (last_beat) pkt_cnt[grant_id_o] <= pkt_cnt[grant_id_o] + 32'd1;
      if (grant_valid_o && credits_o == '0) pmu_stall_cnt_o <= pmu_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wrr_packet_scheduler.sv
module tb_wrr_packet_scheduler;
  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [4:0]      req = '0;
  logic [4:0][7:0] len = '0;
  logic [4:0][3:0] wgt = '0;
  logic            fire = 1'b0, ret = 1'b0;
  logic            grant_valid, beat_allow, pkt_done;
  logic [4:0]      grant;
  logic [2:0]      grant_id;
  logic [3:0]      credits;
  int              n_chk = 0, n_fail = 0;
`ifdef SCHED_PMU_EN
  logic                 pmu_clear = 1'b0;
  logic [4:0][31:0]     pmu_pkt;
  logic [31:0]          pmu_stall;
`endif

  always #5 clk_i = ~clk_i;

  wrr_packet_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req), .len_i(len), .weight_i(wgt),
    .beat_fire_i(fire), .credit_return_i(ret),
    .grant_valid_o(grant_valid), .grant_o(grant), .grant_id_o(grant_id),
    .beat_allow_o(beat_allow), .credits_o(credits), .pkt_done_o(pkt_done)
`ifdef SCHED_PMU_EN
    , .pmu_clear_i(pmu_clear), .pmu_pkt_cnt_o(pmu_pkt), .pmu_stall_cnt_o(pmu_stall)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  initial begin
    int exp3 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

    // Reset values
    do_reset();
    chk("rst_valid", grant_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_id", grant_id, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_credits", credits, 8);
    chk("rst_allow", beat_allow, 0);

    // Single 3-beat packet on channel 2
    wgt = {5{4'd1}};
    len[2] = 8'd3;
    req = 5'b00100;
    tick();
    chk("t1_valid", grant_valid, 1);
    chk("t1_id", grant_id, 2);
    chk("t1_onehot", grant, 5'b00100);
    req = '0;
    fire = 1'b1;
    tick(); chk("t1_cred7", credits, 7);
    chk("t1_nodone", pkt_done, 0);
    tick(); chk("t1_cred6", credits, 6);
    tick();
    chk("t1_done", pkt_done, 1);
    chk("t1_idle", grant_valid, 0);
    chk("t1_cred5", credits, 5);
    fire = 1'b0;
    tick(); chk("t1_done_pulse", pkt_done, 0);

    // Round robin, all weights 1, len 1
    do_reset();
    len = {5{8'd1}};
    req = 5'b11111;
    fire = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t2_valid%0d", k), grant_valid, 1);
      chk($sformatf("t2_id%0d", k), grant_id, k % 5);
      tick();
      chk($sformatf("t2_done%0d", k), pkt_done, 1);
      chk($sformatf("t2_gap%0d", k), grant_valid, 0);
    end
    chk("t2_credits", credits, 2);

    // Weighted: ch0 weight 3, ch1 weight 1, len 2; returns keep credits at max
    fire = 1'b0;
    do_reset();
    wgt = {5{4'd1}};
    wgt[0] = 4'd3;
    len = {5{8'd2}};
    req = 5'b00011;
    fire = 1'b1;
    ret = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("t3_id%0d", k), grant_id, exp3[k]);
      tick(); tick();
      chk($sformatf("t3_done%0d", k), pkt_done, 1);
    end
    chk("t3_cred_sat", credits, 8);

    // Credit stall: drain to 2 with a 6-beat packet, then a 4-beat packet
    fire = 1'b0; ret = 1'b0;
    do_reset();
    wgt = {5{4'd1}};
    len = '0;
    len[0] = 8'd6;
    req = 5'b00001;
    fire = 1'b1;
    tick();
    chk("t4_id", grant_id, 0);
    len[0] = 8'd4;  // ignored while BUSY
    for (int k = 0; k < 5; k++) tick();
    chk("t4_len_held", pkt_done, 0);
    tick();
    chk("t4_done6", pkt_done, 1);
    chk("t4_cred2", credits, 2);
    tick();
    chk("t4_regrant", grant_valid, 1);
    req = '0;
    tick(); chk("t4_cred1", credits, 1);
    tick();
    chk("t4_cred0", credits, 0);
    chk("t4_allow0", beat_allow, 0);
    chk("t4_held", grant_valid, 1);
    tick();
    chk("t4_stall_cred", credits, 0);
    chk("t4_stall_nodone", pkt_done, 0);
    chk("t4_stall_valid", grant_valid, 1);
    ret = 1'b1;
    tick();
    chk("t4_ret1", credits, 1);
    chk("t4_allow1", beat_allow, 1);
    ret = 1'b0;
    tick();
    chk("t4_beat3", credits, 0);
    chk("t4_beat3_valid", grant_valid, 1);
    ret = 1'b1;
    tick();
    ret = 1'b0;
    chk("t4_ret2", credits, 1);
    tick();
    chk("t4_done4", pkt_done, 1);
    chk("t4_end_valid", grant_valid, 0);
    chk("t4_end_cred", credits, 0);

    // Weight 0 disables a channel
    fire = 1'b0;
    do_reset();
    wgt = {5{4'd1}};
    wgt[1] = 4'd0;
    len = {5{8'd1}};
    req = 5'b00010;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t5_nogrant%0d", k), grant_valid, 0);
    end
    req = 5'b00110;
    tick();
    chk("t5_skip_id", grant_id, 2);
    chk("t5_skip_valid", grant_valid, 1);

    // Asynchronous reset mid-packet
    do_reset();
    len[0] = 8'd5;
    req = 5'b00001;
    fire = 1'b1;
    tick();
    req = '0;
    tick(); tick();
    chk("t6_pre_cred", credits, 6);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_valid", grant_valid, 0);
    chk("t6_grant", grant, 0);
    chk("t6_id", grant_id, 0);
    chk("t6_cred", credits, 8);
    chk("t6_allow", beat_allow, 0);
    fire = 1'b0;
    rst_i = 1'b0;

`ifdef SCHED_PMU_EN
    // Four 1-beat packets on channel 3, then a long packet that stalls
    do_reset();
    wgt = {5{4'd1}};
    len = '0;
    len[3] = 8'd1;
    req = 5'b01000;
    fire = 1'b1;
    for (int k = 0; k < 4; k++) begin tick(); tick(); end
    len[3] = 8'd6;
    tick();   // idle gap, packet 5 granted at this edge
    req = '0;
    for (int k = 0; k < 4; k++) tick();   // credits 4 -> 0
    for (int k = 0; k < 5; k++) tick();   // five stalled cycles
    chk("pmu_pkt3", pmu_pkt[3], 4);
    chk("pmu_stall", pmu_stall, 5);
    pmu_clear = 1'b1;
    tick();
    pmu_clear = 1'b0;
    chk("pmu_clr_pkt", pmu_pkt[3], 0);
    chk("pmu_clr_stall", pmu_stall, 0);
    fire = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
